// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment types, blanking constant, bit positions and hex glyph table
package seg7_pkg;
    typedef logic [6:0] seg_t;
    localparam seg_t SEG_OFF = 7'b1111111;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam seg_t HEX_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: display driver bus; SEG7_SCAN_DP_EN adds dp_mask/dp
interface seg7_scan_decoder_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int N      = 3
) ();
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     an;
    seg_t                  seg;
    logic [N-1:0]          idx;
    logic                  frame_done;
`ifdef SEG7_SCAN_DP_EN
    logic [DIGITS-1:0]     dp_mask;
    logic                  dp;
    modport master (output en, load, value, blank_mask, dp_mask, input an, seg, idx, frame_done, dp);
    modport slave  (input en, load, value, blank_mask, dp_mask, output an, seg, idx, frame_done, dp);
`else
    modport master (output en, load, value, blank_mask, input an, seg, idx, frame_done);
    modport slave  (input en, load, value, blank_mask, output an, seg, idx, frame_done);
`endif
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low segment lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output seg_t       seg
);
    assign seg = HEX_TABLE[nib];
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: time-multiplexed 7-segment scanner; SEG7_SCAN_DP_EN adds decimal points
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int N        = 3,
    parameter int SCAN_DIV = 1000,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_decoder_if.slave bus
);
    if (DIGITS > 2**N) begin : g_bad_n
        $error("DIGITS does not fit in N index bits");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
        $error("SCAN_DIV must be at least 1");
    end
    if (SCAN_DIV > 2**CNT_W) begin : g_bad_cnt
        $error("SCAN_DIV does not fit in CNT_W prescaler bits");
    end

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [DIGITS-1:0]   an_q, an_d;
    seg_t                seg_q, seg_d;
    logic                frame_done_q, frame_done_d;
    logic                adv, lit;
    logic [3:0]          nib;
    seg_t                hex_seg;
`ifdef SEG7_SCAN_DP_EN
    logic [DIGITS-1:0]   dpm_q, dpm_d;
    logic                dp_q, dp_d;
`endif

    assign nib = val_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_hex (.nib(nib), .seg(hex_seg));

    // Prescaler/index advance, shadow capture and next display pattern from current idx/shadow
    always_comb begin
        adv          = bus.en && cnt_q == CNT_W'(SCAN_DIV - 1);
        cnt_d        = !bus.en ? cnt_q : adv ? '0 : cnt_q + 1'b1;
        idx_d        = !adv ? idx_q : idx_q == N'(DIGITS - 1) ? '0 : idx_q + 1'b1;
        frame_done_d = adv && idx_q == N'(DIGITS - 1);
        val_d        = bus.load ? bus.value : val_q;
        mask_d       = bus.load ? bus.blank_mask : mask_q;
        lit          = bus.en && !mask_q[idx_q];
        an_d         = lit ? ~(DIGITS'(1) << idx_q) : '1;
        seg_d        = lit ? hex_seg : SEG_OFF;
`ifdef SEG7_SCAN_DP_EN
        dpm_d        = bus.load ? bus.dp_mask : dpm_q;
        dp_d         = lit ? ~dpm_q[idx_q] : 1'b1;
`endif
    end

    // State and registered outputs; reset leaves the display dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            val_q        <= '0;
            mask_q       <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dpm_q        <= '0;
            dp_q         <= 1'b1;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            val_q        <= val_d;
            mask_q       <= mask_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
`ifdef SEG7_SCAN_DP_EN
            dpm_q        <= dpm_d;
            dp_q         <= dp_d;
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.idx        = idx_q;
    assign bus.frame_done = frame_done_q;
`ifdef SEG7_SCAN_DP_EN
    assign bus.dp         = dp_q;
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: two configurations (8 digits/div 4, 5 digits/div 1) against a scan-position model
module tb_seg7_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.DIGITS(8), .N(3)) ia ();
    seg7_scan_decoder_if #(.DIGITS(5), .N(3)) ib ();

    seg7_scan_decoder #(.DIGITS(8), .N(3), .SCAN_DIV(4), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    seg7_scan_decoder #(.DIGITS(5), .N(3), .SCAN_DIV(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam int DD  [2] = '{8, 5};
    localparam int SDV [2] = '{4, 1};

    logic        en, load;
    logic [31:0] value;
    logic [7:0]  mask, dpm;

    assign ia.en = en;
    assign ia.load = load;
    assign ia.value = value;
    assign ia.blank_mask = mask;
    assign ib.en = en;
    assign ib.load = load;
    assign ib.value = value[19:0];
    assign ib.blank_mask = mask[4:0];
`ifdef SEG7_SCAN_DP_EN
    assign ia.dp_mask = dpm;
    assign ib.dp_mask = dpm[4:0];
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    int          pos [2];
    logic [31:0] sv [2];
    logic [7:0]  sm [2];
    logic [7:0]  sp [2];
    logic [7:0]  e_an [2];
    logic [6:0]  e_seg [2];
    int          e_idx [2];
    logic        e_fd [2];
    logic        e_dp [2];
    int          fdc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0;
            sv[k] = '0;
            sm[k] = '0;
            sp[k] = '0;
        end
    endtask

    task automatic check_reset_values();
        check("rst_an_a", 32'(ia.an), 32'hFF);
        check("rst_seg_a", 32'(ia.seg), 32'h7F);
        check("rst_idx_a", 32'(ia.idx), 32'd0);
        check("rst_fd_a", 32'(ia.frame_done), 32'd0);
        check("rst_an_b", 32'(ib.an), 32'h1F);
        check("rst_seg_b", 32'(ib.seg), 32'h7F);
        check("rst_idx_b", 32'(ib.idx), 32'd0);
        check("rst_fd_b", 32'(ib.frame_done), 32'd0);
`ifdef SEG7_SCAN_DP_EN
        check("rst_dp_a", 32'(ia.dp), 32'd1);
        check("rst_dp_b", 32'(ib.dp), 32'd1);
`endif
    endtask

    // One clock: predict from scan position and shadow contents, then compare both DUTs
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            int   i;
            logic lit;
            i = (pos[k] / SDV[k]) % DD[k];
            lit = en && !sm[k][i];
            e_an[k] = lit ? ~(8'd1 << i) : 8'hFF;
            e_seg[k] = lit ? HEX[sv[k][4*i +: 4]] : 7'h7F;
            e_dp[k] = lit ? ~sp[k][i] : 1'b1;
            if (en) pos[k]++;
            e_fd[k] = en && (pos[k] % (DD[k] * SDV[k]) == 0);
            e_idx[k] = (pos[k] / SDV[k]) % DD[k];
            if (load) begin
                sv[k] = value;
                sm[k] = mask;
                sp[k] = dpm;
            end
        end
        @(posedge clk);
        #1;
        check("an_a", 32'(ia.an), 32'(e_an[0]));
        check("seg_a", 32'(ia.seg), 32'(e_seg[0]));
        check("idx_a", 32'(ia.idx), 32'(e_idx[0]));
        check("fd_a", 32'(ia.frame_done), 32'(e_fd[0]));
        check("an_b", 32'(ib.an), 32'(e_an[1][4:0]));
        check("seg_b", 32'(ib.seg), 32'(e_seg[1]));
        check("idx_b", 32'(ib.idx), 32'(e_idx[1]));
        check("fd_b", 32'(ib.frame_done), 32'(e_fd[1]));
`ifdef SEG7_SCAN_DP_EN
        check("dp_a", 32'(ia.dp), 32'(e_dp[0]));
        check("dp_b", 32'(ib.dp), 32'(e_dp[1]));
`endif
    endtask

    initial begin
        en = 1'b0;
        load = 1'b0;
        value = '0;
        mask = '0;
        dpm = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;

        value = 32'h76543210;
        mask = 8'h00;
        dpm = 8'h04;
        load = 1'b1;
        tick();
        load = 1'b0;
        en = 1'b1;
        fdc = 0;
        repeat (64) begin
            tick();
            fdc += int'(ia.frame_done);
        end
        check("fd_count_a", 32'(fdc), 32'd2);

        for (int j = 0; j < 4 && pos[0] % 4 != 3; j++) tick();
        value = 32'hFEDCBA98;
        mask = 8'h80;
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (40) tick();

        for (int j = 0; j < 40 && pos[0] % 32 != 14; j++) tick();
        en = 1'b0;
        repeat (10) tick();
        en = 1'b1;
        repeat (20) tick();

        #2;
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        repeat (12) tick();

        repeat (2000) begin
            en = $urandom_range(0, 9) != 0;
            load = $urandom_range(0, 15) == 0;
            value = $urandom;
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            dpm = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Time-multiplexed 7-segment display driver for the board's seg/anode interface.
- Latches a packed hex word and scans one digit at a time.
- Per digit: decodes the binary digit index to a one-hot anode select and the 4-bit nibble to segment patterns.
- Sits between core/debug registers and the on-board display pins; pairs with the priority/one-hot encoders used on board inputs.

Parameters:
- DIGITS, 8, number of display digits.
- N, 3, digit index width; elaboration error if DIGITS > 2**N.
- SCAN_DIV, 1000, clk cycles each digit is held; must be >= 1.
- CNT_W, 16, prescaler width; elaboration error if SCAN_DIV > 2**CNT_W.

Ports:
- clk  in  1  clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces display dark.
- load  in  1  capture strobe for value/blank_mask.
- value  in  4*DIGITS  nibble k drives digit k (digit 0 = value[3:0]).
- blank_mask  in  DIGITS  bit k=1 turns digit k fully off.
- an  out  DIGITS  anode select, one-hot active-low (bit k=0 means digit k lit).
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- idx  out  N  current digit index.
- frame_done  out  1  one-cycle pulse when the index wraps DIGITS-1 -> 0.

Behaviour:
- Reset (async, immediate):
  - shadow value and mask = 0; prescaler = 0; idx = 0.
  - an = all 1s; seg = 7'b1111111; frame_done = 0.
- Load:
  - load=1 at an edge copies value/blank_mask into the shadow registers.
  - Independent of en; the display uses shadow registers only.
- Prescaler:
  - While en=1, counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it returns to 0 and idx advances.
  - idx wraps DIGITS-1 -> 0 (also for non-power-of-2 DIGITS).
  - SCAN_DIV=1 advances idx every cycle.
- frame_done: registered; high for exactly the cycle after idx becomes 0 by wrap. Never asserted on reset or by en toggling.
- Outputs: registered, 1-cycle latency from (idx, shadow) to (an, seg).
  - an = ~(1 << idx).
  - seg = hex pattern of the shadow nibble at idx.
- Blanking: if shadow blank_mask[idx]=1, an bit stays 1 and seg = all 1s.
- Hex table (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- en=0:
  - Prescaler and idx hold their values.
  - Next cycle an = all 1s, seg = all 1s.
  - Re-enable resumes from the held count; no reset of scan state.
- load coincident with an idx advance: the new idx shows the new shadow nibble. Both take effect on the same edge, so outputs reflect them one cycle later.
- Reset asserted mid-scan: immediate return to reset values; first digit shown is digit 0 one cycle after rst deasserts with en=1.

Optional Feature:
- Macro: SEG7_SCAN_DP_EN.
- Defined:
  - Adds input dp_mask [DIGITS-1:0], captured by load like value.
  - Adds output dp (active-low) = ~shadow_dp[idx], forced 1 when blanked or en=0. Same 1-cycle latency.
  - Reset value of dp = 1.
- Undefined: no dp port, no dp shadow register; behaviour otherwise identical.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry active-low hex segment constant table.
  - SEG_OFF = 7'b1111111.
  - Segment bit-position constants.
- Sub-module seg7_hex_decode: combinational 4-bit -> 7-bit lookup from the package. Instantiated once on the muxed nibble.
- Anode one-hot decode stays inline.

Test Plan:
- Reset release, SCAN_DIV=4, DIGITS=8, load value=32'h76543210, en=1:
  - an steps 11111110, 11111101, ... every 4 cycles.
  - seg 1000000, 1111001, 0100100, ... in order.
  - frame_done pulses once per 32 cycles.
- Load value=32'hFEDCBA98 with blank_mask=8'h80 mid-scan, on the same edge as an idx advance:
  - Next digit shows the new nibble one cycle later.
  - Digit 7 keeps an bit 7 = 1 and seg = 1111111.
- Drop en for 10 cycles at idx=3, prescaler=2:
  - an and seg go all 1s one cycle later.
  - On re-enable, idx=3 resumes and advances after 2 more cycles.
  - No spurious frame_done.
- Assert rst asynchronously between edges mid-frame: an, seg, idx and frame_done reach reset values without a clock edge; scan restarts at digit 0.
- SCAN_DIV=1, DIGITS=5: idx sequence 0,1,2,3,4,0; frame_done every 5 cycles; an never selects a bit >= 5.
- With SEG7_SCAN_DP_EN defined, dp_mask=8'h04: dp=0 only while digit 2 is displayed; dp=1 when en=0.
